// File: rtl/mux4.sv
// Purpose : 4:1 data multiplexer with a combinational output and a registered,
//           valid-qualified copy of the selected data.
// Latency : y is combinational (0 cycles); y_q/sel_q/out_valid(/y_par) 1 clk edge.
// Backpressure: none; the consumer must take y_q in the cycle out_valid is high.
//
// Optional feature macro: MUX4_PARITY_EN adds the y_par output and its register.
//
// Ports:
//   clk        rising-edge clock for all registered outputs
//   rst_n      asynchronous active-low reset (clears registered outputs only)
//   i0..i3     WIDTH-bit data sources
//   sel        2-bit source select (00->i0, 01->i1, 10->i2, 11->i3)
//   in_valid   capture strobe for the registered path
//   y          combinational selected data (live during reset)
//   y_q        registered selected data, loaded when in_valid is sampled high
//   sel_q      select value captured together with y_q
//   out_valid  single-cycle pulse: y_q/sel_q were loaded on the previous edge
//   y_par      even parity (XOR-reduce) of y_q  [MUX4_PARITY_EN only]
module mux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [1:0]       sel_q,
  output logic             out_valid
`ifdef MUX4_PARITY_EN
  ,
  output logic             y_par
`endif
);

  // Combinational select. An unknown select falls into the default arm so
  // simulation shows a fully-X y instead of a partially merged value.
  always_comb begin
    y = 'x;
    case (sel)
      2'b00:   y = i0;
      2'b01:   y = i1;
      2'b10:   y = i2;
      2'b11:   y = i3;
      default: y = 'x;
    endcase
  end

  // Registered path: data and select only move on capture edges, while the
  // valid flag follows in_valid every edge so it forms a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      sel_q     <= 2'b00;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y_q   <= y;
        sel_q <= sel;
      end
    end
  end

`ifdef MUX4_PARITY_EN
  // Parity is registered alongside y_q from the same source so it always
  // matches y_q without an XOR tree on the registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_par <= 1'b0;
    end else if (in_valid) begin
      y_par <= ^y;
    end
  end
`endif

endmodule

// File: tb/tb_mux4.sv
`timescale 1ns/1ps
module tb_mux4;

  logic clk;
  logic rst_n;

  // WIDTH=1 instance
  logic [0:0] a0, a1, a2, a3;
  logic [1:0] sel1;
  logic       vld1;
  logic [0:0] y1, yq1;
  logic [1:0] selq1;
  logic       ov1;
`ifdef MUX4_PARITY_EN
  logic       par1;
`endif

  // WIDTH=8 instance
  logic [7:0] b0, b1, b2, b3;
  logic [1:0] sel8;
  logic       vld8;
  logic [7:0] y8, yq8;
  logic [1:0] selq8;
  logic       ov8;
`ifdef MUX4_PARITY_EN
  logic       par8;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] y;
    logic [1:0] sel;
    logic       par;
  } exp_t;

  exp_t sb[$];

  mux4 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i0(a0), .i1(a1), .i2(a2), .i3(a3),
    .sel(sel1), .in_valid(vld1),
    .y(y1), .y_q(yq1), .sel_q(selq1), .out_valid(ov1)
`ifdef MUX4_PARITY_EN
    , .y_par(par1)
`endif
  );

  mux4 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .i0(b0), .i1(b1), .i2(b2), .i3(b3),
    .sel(sel8), .in_valid(vld8),
    .y(y8), .y_q(yq8), .sel_q(selq8), .out_valid(ov8)
`ifdef MUX4_PARITY_EN
    , .y_par(par8)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one capture on the 8-bit instance and queue the hand-computed result.
  task automatic drive8(input logic [1:0] s, input logic [7:0] v, input logic p);
    exp_t e;
    sel8 = s;
    vld8 = 1'b1;
    #1;
    chk("y8_comb", y8, v);
    e.y   = v;
    e.sel = s;
    e.par = p;
    sb.push_back(e);
  endtask

  // Monitor: whenever the 8-bit instance presents out_valid, pop and compare.
  always @(negedge clk) begin
    if (rst_n && ov8) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_valid: out_valid=1 with y_q=0x%0h, expected no output", yq8);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_y_q", yq8, e.y);
        chk("sb_sel_q", selq8, e.sel);
`ifdef MUX4_PARITY_EN
        chk("sb_y_par", par8, e.par);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  logic [7:0] tbl [4];

  initial begin
    tbl[0] = 8'hA5; tbl[1] = 8'h3C; tbl[2] = 8'hFF; tbl[3] = 8'h00;
    rst_n = 1'b0;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0; sel1 = 2'b00; vld1 = 1'b0;
    b0 = 8'hA5; b1 = 8'h3C; b2 = 8'hFF; b3 = 8'h00; sel8 = 2'b10; vld8 = 1'b1;

    // Reset state; in_valid high during reset must be ignored.
    repeat (2) @(negedge clk);
    chk("rst_y_q1", yq1, 0);
    chk("rst_sel_q1", selq1, 0);
    chk("rst_ov1", ov1, 0);
    chk("rst_y_q8", yq8, 0);
    chk("rst_sel_q8", selq8, 0);
    chk("rst_ov8", ov8, 0);
    chk("rst_y8_live", y8, 8'hFF);
`ifdef MUX4_PARITY_EN
    chk("rst_par8", par8, 0);
`endif
    vld8 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ov8", ov8, 0);
    chk("post_rst_y_q8", yq8, 0);

    // One-hot selection, WIDTH=1.
    for (int s = 0; s < 4; s++) begin
      a0 = (s == 0); a1 = (s == 1); a2 = (s == 2); a3 = (s == 3);
      sel1 = 2'(s);
      #1;
      chk($sformatf("onehot_sel%0d", s), y1, 1);
    end

    // Selection isolation on sel=10.
    sel1 = 2'b10; a0 = 1; a1 = 1; a2 = 0; a3 = 1;
    #1; chk("iso_base", y1, 0);
    a0 = 0; #1; chk("iso_i0", y1, 0);
    a1 = 0; #1; chk("iso_i1", y1, 0);
    a3 = 0; #1; chk("iso_i3", y1, 0);
    a0 = 1; a1 = 1; a3 = 1; #1; chk("iso_restore", y1, 0);
    a2 = 1; #1; chk("iso_selected", y1, 1);

    // WIDTH=8 sweep with in_valid held high, then parity capture of 8'h07.
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      drive8(2'(s), tbl[s], 1'b0);
      @(negedge clk);
    end
    b1 = 8'h07;
    drive8(2'b01, 8'h07, 1'b1);
    @(negedge clk);
    vld8 = 1'b0;
    @(negedge clk);
    chk("hold_ov8", ov8, 0);
    chk("hold_y_q8", yq8, 8'h07);
`ifdef MUX4_PARITY_EN
    chk("hold_par8", par8, 1);
`endif

    // Registered capture, WIDTH=1.
    sel1 = 2'b11; a0 = 0; a1 = 0; a2 = 0; a3 = 1; vld1 = 1'b1;
    @(negedge clk);
    vld1 = 1'b0;
    chk("cap_y_q1", yq1, 1);
    chk("cap_sel_q1", selq1, 2'b11);
    chk("cap_ov1", ov1, 1);
    @(negedge clk);
    chk("cap_ov1_drop", ov1, 0);
    chk("cap_y_q1_hold", yq1, 1);
    chk("cap_sel_q1_hold", selq1, 2'b11);

    // Async reset mid-stream while out_valid is high.
    vld1 = 1'b1;
    drive8(2'b01, 8'h07, 1'b1);
    @(negedge clk);
    vld1 = 1'b0;
    vld8 = 1'b0;
    chk("pre_rst_ov1", ov1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_y_q1", yq1, 0);
    chk("arst_sel_q1", selq1, 0);
    chk("arst_ov1", ov1, 0);
    chk("arst_y_q8", yq8, 0);
    chk("arst_ov8", ov8, 0);
`ifdef MUX4_PARITY_EN
    chk("arst_par8", par8, 0);
`endif
    a3 = 0; #1; chk("arst_y1_live0", y1, 0);
    a3 = 1; #1; chk("arst_y1_live1", y1, 1);
    sel8 = 2'b00; #1; chk("arst_y8_live", y8, 8'hA5);
    #2 rst_n = 1'b1;

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("final_ov8", ov8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
